// File: rtl/vfifo_pkg.sv
// Shared definitions for the vfifo synchronous FIFO: sizing helpers and read-mode encodings.
package vfifo_pkg;

    // Read-mode encodings used for the FWFT parameter of vfifo_sync_fifo.
    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Number of words addressed by an ADDR_WIDTH-bit pointer.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Occupancy counter width; one extra bit so that level == DEPTH is representable.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/vfifo_sdp_ram.sv
// Single-clock simple dual-port RAM: one write port, one read port with a registered
// read address and a combinational data output from that registered address.
module vfifo_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] adr_a,
    input  logic [DATA_WIDTH-1:0] d_a,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] adr_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_adr_b;

    // Write port and read-address register; re holds the address so q_b stays stable.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[adr_a] <= d_a;
        end
        if (re) begin
            r_adr_b <= adr_b;
        end
    end

    assign q_b = r_mem[r_adr_b];

endmodule

// File: rtl/vfifo_sync_fifo.sv
// Single-clock FIFO around vfifo_sdp_ram: pointer/occupancy control, full/empty and
// almost flags, sticky overflow/underflow, synchronous flush, standard or FWFT read mode.
//
// Handshake: wr_en and rd_en are requests sampled on the rising edge. A write transfers
// iff wr_en && !full, a read (FWFT: pop of the head) transfers iff rd_en && !empty, both
// judged on the flag values before the edge; a refused request is dropped and latches
// overflow/underflow. clr wins over both requests in the same cycle.
module vfifo_sync_fifo
    import vfifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int LW = level_width(ADDR_WIDTH);
    localparam logic [LW-1:0] DEPTH_L  = LW'(fifo_depth(ADDR_WIDTH));
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_rd;
    logic [DATA_WIDTH-1:0] w_q_b;

    assign w_full   = (r_level == DEPTH_L);
    assign w_wr_acc = wr_en && !w_full && !clr;
    assign w_rd_acc = rd_en && !w_empty && !clr;

    vfifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc),
        .adr_a (r_wr_ptr),
        .d_a   (din),
        .re    (w_ram_rd),
        .adr_b (r_rd_ptr),
        .q_b   (w_q_b)
    );

    if (FWFT == int'(RD_FWFT)) begin : g_fwft
        // Two prefetch stages: s1 is the RAM output (word addressed by the registered
        // read address), the output register holds the visible head word.
        logic                  r_s1_valid;
        logic                  r_out_valid;
        logic [DATA_WIDTH-1:0] r_out_data;
        logic [LW-1:0]         w_ram_cnt;
        logic                  w_out_load;
        logic                  w_s1_free;

        // Words still waiting in the RAM behind the two prefetch stages.
        assign w_ram_cnt  = r_level - LW'(r_s1_valid) - LW'(r_out_valid);
        assign w_out_load = !r_out_valid || w_rd_acc;
        assign w_s1_free  = !r_s1_valid || w_out_load;
        assign w_ram_rd   = !clr && (w_ram_cnt != '0) && w_s1_free;

        // Advance the prefetch pipeline: s1 -> output register, RAM -> s1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1_valid  <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else if (clr) begin
                r_s1_valid  <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else begin
                if (w_out_load) begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_out_data <= w_q_b;
                    end
                end
                if (w_s1_free) begin
                    r_s1_valid <= w_ram_rd;
                end
            end
        end

        assign w_empty    = !r_out_valid;
        assign dout       = r_out_data;
        assign dout_valid = r_out_valid;
    end else begin : g_std
        logic r_dout_valid;

        assign w_ram_rd = w_rd_acc;

        // Data from an accepted read is presented for exactly the following cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_rd_acc;
            end
        end

        assign w_empty    = (r_level == '0);
        assign dout       = r_dout_valid ? w_q_b : '0;
        assign dout_valid = r_dout_valid;
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + LW'(1);
            end else if (!w_wr_acc && w_rd_acc) begin
                r_level <= r_level - LW'(1);
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = r_level;
    assign almost_full  = (r_level >= AFULL_L);
    assign almost_empty = (r_level <= AEMPTY_L);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_vfifo_sync_fifo.sv
// Bench for vfifo_sync_fifo: a standard-mode and an FWFT-mode instance share one stimulus
// stream and are each compared every cycle against a queue-based reference model.
module tb_vfifo_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          clr   = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din   = '0;

    logic [DW-1:0] dout_s, dout_f;
    logic          dval_s, dval_f, full_s, full_f, empty_s, empty_f;
    logic          af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [AW:0]   level_s, level_f;

    vfifo_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_s), .dout_valid(dval_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .level(level_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    vfifo_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout_f), .dout_valid(dval_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .level(level_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] exp_q[$];     // standard-mode contents, head first
    logic [DW-1:0] fw_q[$];      // FWFT-mode contents, head first
    int            fw_t_q[$];    // edge index at which each FWFT word was written
    logic          m_ovf_s, m_unf_s, m_ovf_f, m_unf_f;
    logic          m_dval_s;
    logic [DW-1:0] m_dout_s;
    int            edge_cnt = 0;
    logic          s_wr, s_rd, f_wr, f_rd, f_vis;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_model();
        exp_q.delete();
        fw_q.delete();
        fw_t_q.delete();
        m_ovf_s = 1'b0; m_unf_s = 1'b0;
        m_ovf_f = 1'b0; m_unf_f = 1'b0;
        m_dval_s = 1'b0;
        m_dout_s = '0;
    endfunction

    // An FWFT head word is visible once two edges have passed since it was written.
    function automatic logic fw_visible();
        return (fw_q.size() > 0) && (edge_cnt >= fw_t_q[0] + 2);
    endfunction

    initial clear_model();

    // Model update on each rising edge, using pre-edge model state and the driven inputs.
    always @(posedge clk) begin
        f_vis = fw_visible();
        edge_cnt++;
        if (!rst) begin
            if (clr) begin
                clear_model();
            end else begin
                s_wr = wr_en && (exp_q.size() < DEPTH);
                s_rd = rd_en && (exp_q.size() > 0);
                if (wr_en && !s_wr) m_ovf_s = 1'b1;
                if (rd_en && !s_rd) m_unf_s = 1'b1;
                m_dval_s = 1'b0;
                if (s_rd) begin
                    m_dout_s = exp_q.pop_front();
                    m_dval_s = 1'b1;
                end
                if (s_wr) exp_q.push_back(din);

                f_wr = wr_en && (fw_q.size() < DEPTH);
                f_rd = rd_en && f_vis;
                if (wr_en && !f_wr) m_ovf_f = 1'b1;
                if (rd_en && !f_vis) m_unf_f = 1'b1;
                if (f_rd) begin
                    void'(fw_q.pop_front());
                    void'(fw_t_q.pop_front());
                end
                if (f_wr) begin
                    fw_q.push_back(din);
                    fw_t_q.push_back(edge_cnt);
                end
            end
        end
    end

    task automatic check_all();
        int sz_s = exp_q.size();
        int sz_f = fw_q.size();
        logic vis = fw_visible();
        check_eq("s_level", level_s, sz_s);
        check_eq("s_empty", empty_s, sz_s == 0);
        check_eq("s_full", full_s, sz_s == DEPTH);
        check_eq("s_afull", af_s, sz_s >= DEPTH - 2);
        check_eq("s_aempty", ae_s, sz_s <= 2);
        check_eq("s_ovf", ovf_s, m_ovf_s);
        check_eq("s_unf", unf_s, m_unf_s);
        check_eq("s_dval", dval_s, m_dval_s);
        if (m_dval_s) check_eq("s_dout", dout_s, m_dout_s);
        check_eq("f_level", level_f, sz_f);
        check_eq("f_empty", empty_f, !vis);
        check_eq("f_dval", dval_f, vis);
        check_eq("f_full", full_f, sz_f == DEPTH);
        check_eq("f_afull", af_f, sz_f >= DEPTH - 2);
        check_eq("f_aempty", ae_f, sz_f <= 2);
        check_eq("f_ovf", ovf_f, m_ovf_f);
        check_eq("f_unf", unf_f, m_unf_f);
        if (vis) check_eq("f_dout", dout_f, fw_q[0]);
    endtask

    // ---------------- driver tasks ----------------
    // Sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        @(negedge clk);
        check_all();
        wr_en = w;
        din   = d;
        rd_en = r;
        clr   = c;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        check_eq("arst_level_s", level_s, 0);
        check_eq("arst_level_f", level_f, 0);
        check_eq("arst_empty_s", empty_s, 1);
        check_eq("arst_empty_f", empty_f, 1);
        check_eq("arst_dout_s", dout_s, 0);
        check_eq("arst_dout_f", dout_f, 0);
        check_eq("arst_dval_f", dval_f, 0);
        check_all();
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vcnt;
        int wp, rp;

        // reset state
        repeat (2) step(0, '0, 0, 0);
        rst = 1'b0;

        // fill 0x00..0x0F, then a 17th write into a full FIFO
        for (int i = 0; i < 17; i++) step(1, DW'(i), 0, 0);
        step(0, '0, 0, 0);
        check_eq("fill_full_s", full_s, 1);
        check_eq("fill_level_s", level_s, 16);
        check_eq("fill_ovf_s", ovf_s, 1);

        // drain 16 words, then read an empty FIFO
        for (int i = 0; i < 18; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check_eq("drain_empty_s", empty_s, 1);
        check_eq("drain_unf_s", unf_s, 1);
        repeat (3) step(0, '0, 0, 0);
        check_eq("unf_sticky_s", unf_s, 1);
        step(0, '0, 0, 1);

        // level 5, then 40 cycles of simultaneous read and write
        for (int i = 0; i < 5; i++) step(1, DW'(8'h40 + i), 0, 0);
        repeat (3) step(0, '0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, DW'(8'h80 + i), 1, 0);
        step(0, '0, 0, 0);
        check_eq("wrap_level_s", level_s, 5);
        check_eq("wrap_level_f", level_f, 5);

        // level 7, then clr together with wr_en and rd_en
        step(0, '0, 0, 1);
        for (int i = 0; i < 7; i++) step(1, DW'(8'h60 + i), 0, 0);
        step(1, 8'hEE, 1, 1);
        step(0, '0, 0, 0);
        check_eq("clr_level_s", level_s, 0);
        check_eq("clr_empty_f", empty_f, 1);

        // FWFT: single write 0xA5 into an empty FIFO
        step(1, 8'hA5, 0, 0);
        step(0, '0, 0, 0);
        check_eq("a5_e_n", empty_f, 1);
        step(0, '0, 0, 0);
        check_eq("a5_e_n1", empty_f, 1);
        step(0, '0, 0, 0);
        check_eq("a5_e_n2", empty_f, 0);
        check_eq("a5_dout", dout_f, 8'hA5);
        step(0, '0, 1, 0);

        // FWFT: 10 prefilled words popped under continuous rd_en
        step(0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, DW'(8'h30 + i), 0, 0);
        repeat (3) step(0, '0, 0, 0);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, '0, 1, 0);
            if (dval_f) begin
                vcnt++;
                check_eq("burst_dout_f", dout_f, 8'h30 + i);
            end
        end
        step(0, '0, 0, 0);
        check_eq("burst_count_f", vcnt, 10);
        check_eq("burst_empty_f", empty_f, 1);

        // randomized phases with varying write/read pressure, occasional clr and one async reset
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph == 0) ? 85 : (ph == 1) ? 25 : (ph == 2) ? 60 : 50;
            rp = (ph == 0) ? 30 : (ph == 1) ? 85 : (ph == 2) ? 60 : 50;
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < wp, DW'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < rp, $urandom_range(0, 99) == 0);
                if (ph == 2 && i == 100) async_reset();
            end
        end
        step(0, '0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
